// File: rtl/alu_seq_core_pkg.sv
// Shared types and constants for the sequential ALU core.
// Holds opcode classes, opcodes, FSM states and opcode legality.
package alu_seq_core_pkg;

  typedef enum logic [1:0] {
    CLS_ARITH = 2'b00,
    CLS_BOOL  = 2'b01,
    CLS_SHIFT = 2'b10,
    CLS_CMP   = 2'b11
  } alu_cls_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_AND   = 6'b011000;
  localparam logic [5:0] OP_OR    = 6'b011110;
  localparam logic [5:0] OP_XOR   = 6'b010110;
  localparam logic [5:0] OP_A     = 6'b011010;
  localparam logic [5:0] OP_SHL   = 6'b100000;
  localparam logic [5:0] OP_SHR   = 6'b100001;
  localparam logic [5:0] OP_SRA   = 6'b100011;
  localparam logic [5:0] OP_CMPEQ = 6'b110011;
  localparam logic [5:0] OP_CMPLT = 6'b110101;
  localparam logic [5:0] OP_CMPLE = 6'b110111;

  localparam logic [1:0] SH_SHL = 2'b00;
  localparam logic [1:0] SH_SHR = 2'b01;
  localparam logic [1:0] SH_SRA = 2'b11;

  function automatic logic op_legal(
    input logic [5:0] fn
  );
    logic ok;
    case (fn)
      OP_ADD, OP_SUB,
      OP_AND, OP_OR, OP_XOR, OP_A,
      OP_SHL, OP_SHR, OP_SRA,
      OP_CMPEQ, OP_CMPLT, OP_CMPLE:
        ok = 1'b1;
      default:
        ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/alu_seq_core_units.sv
// Combinational ALU building blocks.
// Adder/subtractor with flags, comparator and boolean unit.
module AddSub (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        sub,
  output logic [31:0] s,
  output logic        z,
  output logic        v,
  output logic        n
);
  logic [31:0] bx;

  assign bx = b ^ {32{sub}};
  assign s  = a + bx + {31'b0, sub};
  assign z  = (s == 32'h0);
  assign n  = s[31];
  assign v  = (a[31] & bx[31] & ~s[31]) |
              (~a[31] & ~bx[31] & s[31]);
endmodule

module CmpModule (
  input  logic [1:0] fn,
  input  logic       z,
  input  logic       v,
  input  logic       n,
  output logic       c
);
  always_comb begin
    c = 1'b0;
    case (fn)
      2'b01:   c = z;
      2'b10:   c = n ^ v;
      2'b11:   c = z | (n ^ v);
      default: c = 1'b0;
    endcase
  end
endmodule

module LogicModule (
  input  logic [3:0]  fn,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] r
);
  // Each result bit is a lookup into fn indexed by {b,a}.
  always_comb begin
    r = 32'h0;
    for (int i = 0; i < 32; i++) begin
      r[i] = fn[{b[i], a[i]}];
    end
  end
endmodule

// File: rtl/alu_seq_shifter.sv
// Bit-serial shifter: shift register, mode and down-counter.
// Shifts one position per step until the counter runs out.
module alu_seq_shifter
  import alu_seq_core_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        step,
  input  logic [1:0]  op_in,
  input  logic [31:0] ld_val,
  input  logic [4:0]  ld_amt,
  output logic [31:0] sh_nxt,
  output logic [4:0]  cnt
);
  logic [31:0] sh_q, sh_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [1:0]  op_q, op_d;

  always_comb begin
    sh_nxt = {sh_q[30:0], 1'b0};
    case (op_q)
      SH_SHL:  sh_nxt = {sh_q[30:0], 1'b0};
      SH_SHR:  sh_nxt = {1'b0, sh_q[31:1]};
      SH_SRA:  sh_nxt = {sh_q[31], sh_q[31:1]};
      default: sh_nxt = {sh_q[30:0], 1'b0};
    endcase
  end

  always_comb begin
    sh_d  = sh_q;
    cnt_d = cnt_q;
    op_d  = op_q;
    if (load) begin
      sh_d  = ld_val;
      cnt_d = ld_amt;
      op_d  = op_in;
    end else if (step) begin
      sh_d  = sh_nxt;
      cnt_d = cnt_q - 5'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q  <= 32'h0;
      cnt_q <= 5'd0;
      op_q  <= SH_SHL;
    end else begin
      sh_q  <= sh_d;
      cnt_q <= cnt_d;
      op_q  <= op_d;
    end
  end

  assign cnt = cnt_q;
endmodule

// File: rtl/alu_seq_core.sv
// Sequential ALU with valid/ready handshake on both sides.
// Single-cycle arith/bool/cmp; shifts take one cycle per bit.
module alu_seq_core
  import alu_seq_core_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  alufn,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        z,
  output logic        v,
  output logic        n,
  output logic        err
);
  state_e      state_q, state_d;
  logic [31:0] result_q, result_d;
  logic        z_q, z_d;
  logic        v_q, v_d;
  logic        n_q, n_d;
  logic        err_q, err_d;

  alu_cls_e    cls;
  logic        legal;
  logic        is_shift;
  logic        accept;
  logic        sub;
  logic [31:0] as_s;
  logic        as_z, as_v, as_n;
  logic        cmp_c;
  logic [31:0] log_r;
  logic [31:0] res_c;
  logic        z_c, v_c, n_c, err_c;
  logic        sh_load, sh_step;
  logic [31:0] sh_nxt;
  logic [4:0]  sh_cnt;

  assign cls      = alu_cls_e'(alufn[5:4]);
  assign legal    = op_legal(alufn);
  assign is_shift = legal && (cls == CLS_SHIFT);
  assign sub      = alufn[0] | (cls == CLS_CMP);

  AddSub u_addsub (
    .a   (a),
    .b   (b),
    .sub (sub),
    .s   (as_s),
    .z   (as_z),
    .v   (as_v),
    .n   (as_n)
  );

  CmpModule u_cmp (
    .fn (alufn[2:1]),
    .z  (as_z),
    .v  (as_v),
    .n  (as_n),
    .c  (cmp_c)
  );

  LogicModule u_logic (
    .fn (alufn[3:0]),
    .a  (a),
    .b  (b),
    .r  (log_r)
  );

  alu_seq_shifter u_shifter (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (sh_load),
    .step   (sh_step),
    .op_in  (alufn[1:0]),
    .ld_val (a),
    .ld_amt (b[4:0]),
    .sh_nxt (sh_nxt),
    .cnt    (sh_cnt)
  );

  always_comb begin
    res_c = 32'h0;
    z_c   = 1'b1;
    v_c   = 1'b0;
    n_c   = 1'b0;
    err_c = 1'b0;
    if (!legal) begin
      err_c = 1'b1;
    end else begin
      unique case (cls)
        CLS_ARITH: begin
          res_c = as_s;
          z_c   = as_z;
          v_c   = as_v;
          n_c   = as_n;
        end
        CLS_CMP: begin
          res_c = {31'b0, cmp_c};
          z_c   = as_z;
          v_c   = as_v;
          n_c   = as_n;
        end
        CLS_BOOL: begin
          res_c = log_r;
          z_c   = (log_r == 32'h0);
          n_c   = log_r[31];
        end
        CLS_SHIFT: begin
          res_c = a;
          z_c   = (a == 32'h0);
          n_c   = a[31];
        end
      endcase
    end
  end

  assign in_ready = (state_q == ST_IDLE) ||
                    ((state_q == ST_DONE) && out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    z_d      = z_q;
    v_d      = v_q;
    n_d      = n_q;
    err_d    = err_q;
    sh_load  = 1'b0;
    sh_step  = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept) begin
          if (is_shift && (b[4:0] != 5'd0)) begin
            sh_load = 1'b1;
            state_d = ST_SHIFT;
          end else begin
            state_d  = ST_DONE;
            result_d = res_c;
            z_d      = z_c;
            v_d      = v_c;
            n_d      = n_c;
            err_d    = err_c;
          end
        end else if (state_q == ST_DONE && out_ready) begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        sh_step = 1'b1;
        // The final step's output goes straight to the result.
        if (sh_cnt == 5'd1) begin
          state_d  = ST_DONE;
          result_d = sh_nxt;
          z_d      = (sh_nxt == 32'h0);
          v_d      = 1'b0;
          n_d      = sh_nxt[31];
          err_d    = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      result_q <= 32'h0;
      z_q      <= 1'b0;
      v_q      <= 1'b0;
      n_q      <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      z_q      <= z_d;
      v_q      <= v_d;
      n_q      <= n_d;
      err_q    <= err_d;
    end
  end

  assign out_valid = (state_q == ST_DONE);
  assign result    = result_q;
  assign z         = z_q;
  assign v         = v_q;
  assign n         = n_q;
  assign err       = err_q;
endmodule

// File: tb/tb_alu_seq_core.sv
// Directed bench for alu_seq_core.
// Drives and samples on the falling clock edge.
module tb_alu_seq_core;
  import alu_seq_core_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  alufn;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        z, v, n, err;

  int n_chk;
  int n_pass;

  alu_seq_core dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alufn     (alufn),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .z         (z),
    .v         (v),
    .n         (n),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp)
      $display("FAIL %s: got %h exp %h", tag, got, exp);
    else
      n_pass++;
  endtask

  task automatic do_op(
    input string       tag,
    input logic [5:0]  fn,
    input logic [31:0] av,
    input logic [31:0] bv,
    input int          exp_lat,
    input logic [31:0] exp_r,
    input logic        ez,
    input logic        ev,
    input logic        en,
    input logic        eerr
  );
    int w;
    int lat;
    int busy;
    @(negedge clk);
    out_ready = 1'b1;
    alufn     = fn;
    a         = av;
    b         = bv;
    in_valid  = 1'b1;
    w = 0;
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk({tag, "_acc"}, (w < 50), 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a        = ~av;
    b        = bv ^ 32'h0000_0013;
    alufn    = OP_CMPLE;
    lat  = 1;
    busy = 0;
    while (!out_valid && lat < 40) begin
      if (in_ready) busy++;
      @(negedge clk);
      lat++;
    end
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_res"}, result, exp_r);
    chk({tag, "_z"}, z, ez);
    chk({tag, "_v"}, v, ev);
    chk({tag, "_n"}, n, en);
    chk({tag, "_err"}, err, eerr);
    if (exp_lat > 1)
      chk({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    int cnt;
    n_chk     = 0;
    n_pass    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    alufn     = 6'h0;
    a         = 32'h0;
    b         = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_res", result, 32'h0);
    chk("rst_flags", {28'h0, z, v, n, err}, 32'h0);
    chk("rst_ov", out_valid, 0);
    chk("rst_ir", in_ready, 1);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ir", in_ready, 1);

    do_op("add", OP_ADD, 32'h5555_5555, 32'h5555_5555,
          1, 32'hAAAA_AAAA, 0, 1, 1, 0);
    do_op("sub", OP_SUB, 32'h1, 32'h1,
          1, 32'h0, 1, 0, 0, 0);
    do_op("cmplt", OP_CMPLT, 32'h8000_0000, 32'h2,
          1, 32'h1, 0, 1, 0, 0);
    do_op("cmpeq", OP_CMPEQ, 32'h5, 32'h5,
          1, 32'h1, 1, 0, 0, 0);
    do_op("cmple", OP_CMPLE, 32'h3, 32'h2,
          1, 32'h0, 0, 0, 0, 0);
    do_op("or", OP_OR, 32'h0F0F_0000, 32'h0000_F0F0,
          1, 32'h0F0F_F0F0, 0, 0, 0, 0);
    do_op("pass_a", OP_A, 32'hDEAD_BEEF, 32'h1234_5678,
          1, 32'hDEAD_BEEF, 0, 0, 1, 0);
    do_op("shl31", OP_SHL, 32'h1, 32'h1F,
          32, 32'h8000_0000, 0, 0, 1, 0);
    do_op("sra4", OP_SRA, 32'h8000_0000, 32'h4,
          5, 32'hF800_0000, 0, 0, 1, 0);
    do_op("shr4", OP_SHR, 32'h8000_0000, 32'h4,
          5, 32'h0800_0000, 0, 0, 0, 0);
    do_op("shr0", OP_SHR, 32'h1234_5678, 32'h0,
          1, 32'h1234_5678, 0, 0, 0, 0);
    do_op("undef", 6'b111111, 32'h1234_5678, 32'h9,
          1, 32'h0, 1, 0, 0, 1);

    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_idle", out_valid, 0);
    out_ready = 1'b0;
    alufn     = OP_XOR;
    a         = 32'hFFFF_FFFF;
    b         = 32'h0;
    in_valid  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    alufn = OP_AND;
    a     = 32'hF0F0_F0F0;
    b     = 32'h0F0F_0F0F;
    for (int i = 0; i < 5; i++) begin
      chk("bp_ov", out_valid, 1);
      chk("bp_res", result, 32'hFFFF_FFFF);
      chk("bp_ir", in_ready, 0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_ir_hi", in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("b2b_ov", out_valid, 1);
    chk("b2b_res", result, 32'h0);
    chk("b2b_z", z, 1);
    @(negedge clk);
    chk("b2b_drain", out_valid, 0);

    alufn    = OP_SHL;
    a        = 32'h1;
    b        = 32'd10;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ov", out_valid, 0);
    chk("mid_rst_res", result, 32'h0);
    chk("mid_rst_ir", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) cnt++;
    end
    chk("mid_rst_quiet", cnt, 0);
    do_op("after_rst", OP_ADD, 32'h2, 32'h3,
          1, 32'h5, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1, "watchdog");
  end

endmodule
